// File: rtl/axi_ar_error_responder_pkg.sv
// Shared definitions for the AXI node read-path error responder: RRESP encodings
// and the error-burst FSM state type.
package axi_ar_error_responder_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ERR_IDLE  = 2'd0,
        ERR_DRAIN = 2'd1,
        ERR_SEND  = 2'd2
    } err_state_e;

endpackage

// File: rtl/axi_ar_error_responder_if.sv
// Decoder-side control and error R channel of the read error responder.
// The master modport is the decoder/R-mux side; the slave modport is the responder.
interface axi_ar_error_responder_if #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_DATA_WIDTH = 64
);
    logic                      incr_req_i;
    logic                      r_done_i;
    logic                      full_counter_o;
    logic                      outstanding_trans_o;
    logic                      sample_ardata_info_i;
    logic [AXI_ID_WIDTH-1:0]   arid_i;
    logic [7:0]                arlen_i;
    logic [AXI_USER_WIDTH-1:0] aruser_i;
    logic                      error_req_i;
    logic                      error_gnt_o;
    logic                      err_rvalid_o;
    logic                      err_rready_i;
    logic [AXI_ID_WIDTH-1:0]   err_rid_o;
    logic [AXI_DATA_WIDTH-1:0] err_rdata_o;
    logic [1:0]                err_rresp_o;
    logic                      err_rlast_o;
    logic [AXI_USER_WIDTH-1:0] err_ruser_o;

    modport master (
        output incr_req_i, r_done_i, sample_ardata_info_i, arid_i, arlen_i, aruser_i,
               error_req_i, err_rready_i,
        input  full_counter_o, outstanding_trans_o, error_gnt_o, err_rvalid_o,
               err_rid_o, err_rdata_o, err_rresp_o, err_rlast_o, err_ruser_o
    );

    modport slave (
        input  incr_req_i, r_done_i, sample_ardata_info_i, arid_i, arlen_i, aruser_i,
               error_req_i, err_rready_i,
        output full_counter_o, outstanding_trans_o, error_gnt_o, err_rvalid_o,
               err_rid_o, err_rdata_o, err_rresp_o, err_rlast_o, err_ruser_o
    );
endinterface

// File: rtl/axi_outstanding_counter.sv
// Saturating up/down counter of read bursts in flight to real targets, with
// full and non-empty flags decoded from the registered count.
module axi_outstanding_counter #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic incr_req,
    input  logic r_done,
    output logic full_counter,
    output logic outstanding_trans
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (incr_req && !r_done && (count_reg != CNT_MAX)) begin
            count_next = count_reg + 1'b1;
        end else if (r_done && !incr_req && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign full_counter      = (count_reg == CNT_MAX);
    assign outstanding_trans = (count_reg != '0);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(incr_req && !r_done && full_counter))
                else $error("outstanding counter: increment while full");
            assert (!(r_done && !incr_req && !outstanding_trans))
                else $error("outstanding counter: decrement while empty");
        end
    end

endmodule

// File: rtl/axi_ar_error_responder.sv
// Captures an unmapped AR, waits for earlier reads to drain, then plays out a
// full DECERR burst on the error R channel and grants the decoder on its last beat.
module axi_ar_error_responder
    import axi_ar_error_responder_pkg::*;
#(
    parameter int          AXI_ID_WIDTH     = 4,
    parameter int          AXI_USER_WIDTH   = 6,
    parameter int          AXI_DATA_WIDTH   = 64,
    parameter int          MAX_OUTSTANDING  = 8,
    parameter logic [31:0] ERR_DATA_PATTERN = 32'hBADACCE5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_ar_error_responder_if.slave bus
);
    localparam int PATTERN_REPS = AXI_DATA_WIDTH / 32;
    localparam int PATTERN_TAIL = AXI_DATA_WIDTH % 32;

    err_state_e                state_reg, state_next;
    logic [7:0]                beat_cnt_reg, beat_cnt_next;
    logic [AXI_ID_WIDTH-1:0]   arid_reg, arid_next;
    logic [AXI_USER_WIDTH-1:0] aruser_reg, aruser_next;

    logic                      rvalid, rlast, gnt;
    logic [AXI_ID_WIDTH-1:0]   rid;
    logic [AXI_USER_WIDTH-1:0] ruser;
    logic [1:0]                rresp;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [AXI_DATA_WIDTH-1:0] err_data;
    logic                      full_counter, outstanding_trans;

    // The decoder raises error_req alongside the sample strobe; only the strobe matters here.
    logic unused_error_req;
    assign unused_error_req = bus.error_req_i;

    genvar gi;
    generate
        for (gi = 0; gi < PATTERN_REPS; gi++) begin : g_pattern
            assign err_data[gi*32 +: 32] = ERR_DATA_PATTERN;
        end
        if (PATTERN_TAIL != 0) begin : g_pattern_tail
            assign err_data[AXI_DATA_WIDTH-1 : PATTERN_REPS*32] = ERR_DATA_PATTERN[PATTERN_TAIL-1:0];
        end
    endgenerate

    axi_outstanding_counter #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_counter (
        .clk              (clk),
        .rst_n            (rst_n),
        .incr_req         (bus.incr_req_i),
        .r_done           (bus.r_done_i),
        .full_counter     (full_counter),
        .outstanding_trans(outstanding_trans)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ERR_IDLE;
            beat_cnt_reg <= '0;
            arid_reg     <= '0;
            aruser_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            arid_reg     <= arid_next;
            aruser_reg   <= aruser_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        arid_next     = arid_reg;
        aruser_next   = aruser_reg;
        rvalid        = 1'b0;
        rlast         = 1'b0;
        gnt           = 1'b0;
        rid           = '0;
        ruser         = '0;
        rresp         = AXI_RESP_OKAY;
        rdata         = '0;
        unique case (state_reg)
            ERR_IDLE: begin
                if (bus.sample_ardata_info_i) begin
                    state_next    = ERR_DRAIN;
                    arid_next     = bus.arid_i;
                    aruser_next   = bus.aruser_i;
                    beat_cnt_next = bus.arlen_i;
                end
            end
            ERR_DRAIN: begin
                if (!outstanding_trans) begin
                    state_next = ERR_SEND;
                end
            end
            ERR_SEND: begin
                // Payload comes only from registers, so it holds steady under backpressure.
                rvalid = 1'b1;
                rresp  = AXI_RESP_DECERR;
                rid    = arid_reg;
                ruser  = aruser_reg;
                rdata  = err_data;
                rlast  = (beat_cnt_reg == 8'd0);
                if (bus.err_rready_i) begin
                    if (rlast) begin
                        gnt        = 1'b1;
                        state_next = ERR_IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg - 8'd1;
                    end
                end
            end
            default: state_next = ERR_IDLE;
        endcase
    end

    assign bus.full_counter_o      = full_counter;
    assign bus.outstanding_trans_o = outstanding_trans;
    assign bus.error_gnt_o         = gnt;
    assign bus.err_rvalid_o        = rvalid;
    assign bus.err_rid_o           = rid;
    assign bus.err_rdata_o         = rdata;
    assign bus.err_rresp_o         = rresp;
    assign bus.err_rlast_o         = rlast;
    assign bus.err_ruser_o         = ruser;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.sample_ardata_info_i && (state_reg != ERR_IDLE)))
                else $error("error responder: sample strobe outside IDLE");
            assert (!(bus.incr_req_i && (state_reg == ERR_DRAIN)))
                else $error("error responder: new target read while draining");
        end
    end

endmodule

// File: tb/tb_axi_ar_error_responder.sv
// Randomised directed bench for the read error responder, checked against a
// transaction-level model of the counter and of the expected DECERR burst.
module tb_axi_ar_error_responder;
    localparam int MAXO = 8;
    localparam logic [63:0] EXP_DATA = 64'hBADACCE5BADACCE5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_ar_error_responder_if #(.AXI_ID_WIDTH(4), .AXI_USER_WIDTH(6), .AXI_DATA_WIDTH(64)) bus();

    axi_ar_error_responder #(
        .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(6), .AXI_DATA_WIDTH(64),
        .MAX_OUTSTANDING(MAXO), .ERR_DATA_PATTERN(32'hBADACCE5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int model_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counter(input string tag);
        chk({tag, "_count"}, 64'(dut.u_counter.count_reg), 64'(model_cnt));
        chk({tag, "_outstanding"}, 64'(bus.outstanding_trans_o), 64'(model_cnt != 0));
        chk({tag, "_full"}, 64'(bus.full_counter_o), 64'(model_cnt == MAXO));
    endtask

    task automatic pulse(input logic incr, input logic done, input string tag);
        @(negedge clk);
        bus.incr_req_i = incr;
        bus.r_done_i   = done;
        @(negedge clk);
        bus.incr_req_i = 1'b0;
        bus.r_done_i   = 1'b0;
        if (incr && !done && model_cnt < MAXO) model_cnt++;
        else if (done && !incr && model_cnt > 0) model_cnt--;
        #1;
        check_counter(tag);
        $display("counter %s incr=%0b done=%0b model=%0d", tag, incr, done, model_cnt);
    endtask

    task automatic start_err(input logic [3:0] id, input logic [7:0] len, input logic [5:0] user);
        @(negedge clk);
        bus.sample_ardata_info_i = 1'b1;
        bus.error_req_i = 1'b1;
        bus.arid_i   = id;
        bus.arlen_i  = len;
        bus.aruser_i = user;
        @(negedge clk);
        bus.sample_ardata_info_i = 1'b0;
        bus.arid_i   = 4'($urandom);
        bus.arlen_i  = 8'($urandom);
        bus.aruser_i = 6'($urandom);
        #1;
        chk("drain_no_valid", 64'(bus.err_rvalid_o), 64'd0);
    endtask

    // mode 0: rready always high, 1: toggles starting low, 2: random
    task automatic run_burst(input int len, input logic [3:0] id, input logic [5:0] user,
                             input int mode, input bit first_exact, input string tag);
        int beats = 0;
        int cyc = 0;
        int grants = 0;
        bit done = 0;
        bit prev_stall = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            bus.err_rready_i = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            #1;
            if (first_exact && cyc == 0) chk({tag, "_first_beat_time"}, 64'(bus.err_rvalid_o), 64'd1);
            if (prev_stall) chk({tag, "_valid_hold"}, 64'(bus.err_rvalid_o), 64'd1);
            if (bus.err_rvalid_o) begin
                chk({tag, "_rid"}, 64'(bus.err_rid_o), 64'(id));
                chk({tag, "_ruser"}, 64'(bus.err_ruser_o), 64'(user));
                chk({tag, "_rresp"}, 64'(bus.err_rresp_o), 64'd3);
                chk({tag, "_rdata"}, bus.err_rdata_o, EXP_DATA);
                chk({tag, "_rlast"}, 64'(bus.err_rlast_o), 64'(beats == len));
                chk({tag, "_gnt"}, 64'(bus.error_gnt_o), 64'(bus.err_rready_i && beats == len));
                if (bus.error_gnt_o) grants++;
                if (bus.err_rready_i) begin
                    beats++;
                    if (beats == len + 1) done = 1;
                end
            end else begin
                chk({tag, "_gnt_quiet"}, 64'(bus.error_gnt_o), 64'd0);
            end
            prev_stall = bus.err_rvalid_o && !bus.err_rready_i;
            cyc++;
        end
        chk({tag, "_beat_count"}, 64'(beats), 64'(len + 1));
        chk({tag, "_grant_count"}, 64'(grants), 64'd1);
        @(negedge clk);
        bus.err_rready_i = 1'b0;
        bus.error_req_i  = 1'b0;
        #1;
        chk({tag, "_idle_after"}, 64'(bus.err_rvalid_o), 64'd0);
        $display("burst %s len=%0d id=%0h user=%0h beats=%0d cycles=%0d", tag, len, id, user, beats, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rid_r;
        logic [5:0] ruser_r;
        int len_r;
        logic i_r, d_r;

        bus.incr_req_i = 1'b0;
        bus.r_done_i = 1'b0;
        bus.sample_ardata_info_i = 1'b0;
        bus.arid_i = '0;
        bus.arlen_i = '0;
        bus.aruser_i = '0;
        bus.error_req_i = 1'b0;
        bus.err_rready_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_counter("reset");
        chk("reset_rvalid", 64'(bus.err_rvalid_o), 64'd0);
        chk("reset_rlast", 64'(bus.err_rlast_o), 64'd0);
        chk("reset_gnt", 64'(bus.error_gnt_o), 64'd0);
        chk("reset_rid", 64'(bus.err_rid_o), 64'd0);
        chk("reset_ruser", 64'(bus.err_ruser_o), 64'd0);
        chk("reset_rresp", 64'(bus.err_rresp_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter directed
        repeat (3) pulse(1'b1, 1'b0, "incr3");
        pulse(1'b1, 1'b1, "both");
        repeat (3) pulse(1'b0, 1'b1, "done3");
        repeat (MAXO) pulse(1'b1, 1'b0, "fill");
        // Counter random walk inside legal bounds
        for (int k = 0; k < 40; k++) begin
            i_r = 1'($urandom_range(0, 1)) && (model_cnt < MAXO);
            d_r = 1'($urandom_range(0, 1)) && (model_cnt > 0);
            pulse(i_r, d_r, "rand");
        end
        while (model_cnt > 0) pulse(1'b0, 1'b1, "drain");

        // Sample with counter 0: valid at t+2
        start_err(4'h5, 8'd3, 6'h2A);
        run_burst(3, 4'h5, 6'h2A, 0, 1'b1, "basic");

        // Sample with counter 2
        pulse(1'b1, 1'b0, "pre_a");
        pulse(1'b1, 1'b0, "pre_b");
        start_err(4'hA, 8'd2, 6'h11);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("wait_drain_valid", 64'(bus.err_rvalid_o), 64'd0);
        end
        pulse(1'b0, 1'b1, "rd1");
        chk("drain1_valid", 64'(bus.err_rvalid_o), 64'd0);
        pulse(1'b0, 1'b1, "rd2");
        chk("drain2_valid", 64'(bus.err_rvalid_o), 64'd0);
        run_burst(2, 4'hA, 6'h11, 0, 1'b1, "drained");

        // Backpressure
        start_err(4'h3, 8'd1, 6'h3C);
        run_burst(1, 4'h3, 6'h3C, 1, 1'b0, "bp");

        // Random bursts
        for (int k = 0; k < 4; k++) begin
            rid_r = 4'($urandom);
            ruser_r = 6'($urandom);
            len_r = $urandom_range(0, 15);
            start_err(rid_r, 8'(len_r), ruser_r);
            run_burst(len_r, rid_r, ruser_r, 2, 1'b0, "rand");
        end

        // Longest burst
        start_err(4'hF, 8'd255, 6'h01);
        run_burst(255, 4'hF, 6'h01, 0, 1'b1, "len256");

        // Asynchronous reset mid-burst
        start_err(4'h7, 8'd7, 6'h15);
        @(negedge clk);
        bus.err_rready_i = 1'b1;
        bus.incr_req_i = 1'b1;
        #1;
        chk("rst_pre_valid", 64'(bus.err_rvalid_o), 64'd1);
        @(negedge clk);
        bus.incr_req_i = 1'b0;
        bus.err_rready_i = 1'b0;
        model_cnt = 1;
        #1;
        check_counter("rst_pre");
        chk("rst_pre_valid2", 64'(bus.err_rvalid_o), 64'd1);
        #2;
        rst_n = 1'b0;
        model_cnt = 0;
        #1;
        check_counter("rst_mid");
        chk("rst_mid_rvalid", 64'(bus.err_rvalid_o), 64'd0);
        chk("rst_mid_gnt", 64'(bus.error_gnt_o), 64'd0);
        chk("rst_mid_rlast", 64'(bus.err_rlast_o), 64'd0);
        chk("rst_mid_rresp", 64'(bus.err_rresp_o), 64'd0);
        chk("rst_mid_rid", 64'(bus.err_rid_o), 64'd0);
        $display("reset asserted mid-burst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.error_req_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("post_rst_idle", 64'(bus.err_rvalid_o), 64'd0);
        end
        start_err(4'h9, 8'd0, 6'h2F);
        run_burst(0, 4'h9, 6'h2F, 0, 1'b1, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
